axis_corr_arbiter: RTL and testbench

AXIS_CORR_ARBITER -- requirements
Module: axis_corr_arbiter

---
 rtl/axis_corr_arbiter.sv | 128 ++++++++++++
 tb/tb_axis_corr_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axis_corr_arbiter.sv
// Burst arbiter: NUM_SRCS AXI-stream sources share one correlator input, BURST_LEN beats per grant.
// Define AXIS_CORR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module axis_corr_arbiter #(
    parameter int NUM_SRCS   = 4,
    parameter int DATA_WIDTH = 48,
    parameter int BURST_LEN  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRCS-1:0]                s_axis_tvalid,
    output logic [NUM_SRCS-1:0]                s_axis_tready,
    input  logic [NUM_SRCS*DATA_WIDTH-1:0]     s_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [$clog2(NUM_SRCS)-1:0]        m_axis_tdest,
    output logic                               m_axis_tlast
);
    localparam int IDX_W = $clog2(NUM_SRCS);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]            state_reg;
    logic [IDX_W-1:0]      grant_reg;
    logic [IDX_W-1:0]      ptr_reg;
    logic [IDX_W-1:0]      grant_next;
    logic [IDX_W-1:0]      ptr_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  m_valid_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic [IDX_W-1:0]      m_dest_reg;
    logic                  m_last_reg;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRCS];
    logic [NUM_SRCS-1:0]   s_ready;
    logic                  out_free;
    logic                  accept;
    logic                  any_valid;
    logic                  last_beat;

    assign out_free  = ~m_valid_reg | m_axis_tready;
    assign any_valid = |s_axis_tvalid;
    assign accept    = |(s_ready & s_axis_tvalid);
    assign last_beat = (cnt_reg == CNT_W'(BURST_LEN - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRCS; gi++) begin : g_src
            assign src_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            // Ready is also masked by rst so nothing is handed over while reset is held.
            assign s_ready[gi]  = ~rst & (state_reg == ST_BURST) &
                                  (grant_reg == IDX_W'(gi)) & out_free;
        end
    endgenerate

    assign s_axis_tready = s_ready;

    // First asserted source searching upward from ptr, wrapping; fixed priority keeps ptr at 0.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant_next = grant_reg;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            cand = ptr_reg + IDX_W'(i);
            if (!found && s_axis_tvalid[cand]) begin
                grant_next = cand;
                found      = 1'b1;
            end
        end
    end

`ifdef AXIS_CORR_ARB_FIXED_PRIO_EN
    assign ptr_next = '0;
`else
    assign ptr_next = grant_reg + IDX_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_dest_reg  <= '0;
            m_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_reg <= grant_next;
                        state_reg <= ST_BURST;
                    end
                end
                default: begin
                    if (accept) begin
                        if (last_beat) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                            ptr_reg   <= ptr_next;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
            endcase

            if (accept) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= src_data[grant_reg];
                m_dest_reg  <= grant_reg;
                m_last_reg  <= last_beat;
            end else if (m_axis_tready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tdest  = m_dest_reg;
    assign m_axis_tlast  = m_last_reg;
endmodule

// File: tb/tb_axis_corr_arbiter.sv
// Cycle-table bench for axis_corr_arbiter (NUM_SRCS=4, BURST_LEN=4); each source sends {index, sequence} beats.
module tb_axis_corr_arbiter;
    localparam int N  = 4;
    localparam int DW = 48;
    localparam int BL = 4;
`ifdef AXIS_CORR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic [1:0]      m_tdest;
    logic            m_tlast;

    axis_corr_arbiter #(.NUM_SRCS(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tdest  (m_tdest),
        .m_axis_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         start;
        bit         rst;
        logic [3:0] tv;
        bit         mr;
        logic [3:0] rdy;
        bit         mv;
        bit         zero;
        int         dest;
        int         seq;
        bit         last;
    } row_t;

    row_t rows[$];
    int   seq_cnt[N];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input bit start, input bit r_rst, input logic [3:0] tv, input bit mr,
                       input logic [3:0] rdy, input bit mv, input bit zero,
                       input int dest, input int seq, input bit last);
        row_t r;
        r.start = start; r.rst = r_rst; r.tv = tv; r.mr = mr; r.rdy = rdy;
        r.mv = mv; r.zero = zero; r.dest = dest; r.seq = seq; r.last = last;
        rows.push_back(r);
    endtask

    task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < N; i++) seq_cnt[i] = 0;
    endtask

    initial begin
        int d;
        int base;
        logic [DW-1:0] exp_data;

        // Single source 2, sink always ready
        add(1, 0, 4'b0100, 1, 4'b0000, 0, 1, 0, 0, 0);
        add(0, 0, 4'b0100, 1, 4'b0100, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0100, 1, 4'b0100, 1, 0, 2, 1, 0);
        add(0, 0, 4'b0100, 1, 4'b0100, 1, 0, 2, 2, 0);
        add(0, 0, 4'b0100, 1, 4'b0100, 1, 0, 2, 3, 0);
        add(0, 0, 4'b0100, 1, 4'b0000, 1, 0, 2, 4, 1);
        add(0, 0, 4'b0100, 1, 4'b0100, 0, 0, 0, 0, 0);

        // All sources valid: five bursts, one idle cycle between them
        add(1, 0, 4'b1111, 1, 4'b0000, 0, 1, 0, 0, 0);
        for (int b = 0; b < 5; b++) begin
            d    = FIXED ? 0 : b % 4;
            base = FIXED ? b * 4 : (b / 4) * 4;
            add(0, 0, 4'b1111, 1, 4'(1 << d), 0, 0, 0, 0, 0);
            for (int j = 1; j < 4; j++)
                add(0, 0, 4'b1111, 1, 4'(1 << d), 1, 0, d, base + j, 0);
            add(0, 0, 4'b1111, 1, 4'b0000, 1, 0, d, base + 4, 1);
        end

        // Back-pressure: sink ready pattern 1,0,0,1 on source 0
        add(1, 0, 4'b0001, 1, 4'b0000, 0, 1, 0, 0, 0);
        add(0, 0, 4'b0001, 0, 4'b0001, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 0, 4'b0000, 1, 0, 0, 1, 0);
        add(0, 0, 4'b0001, 1, 4'b0001, 1, 0, 0, 1, 0);
        add(0, 0, 4'b0001, 1, 4'b0001, 1, 0, 0, 2, 0);
        add(0, 0, 4'b0001, 0, 4'b0000, 1, 0, 0, 3, 0);
        add(0, 0, 4'b0001, 0, 4'b0000, 1, 0, 0, 3, 0);
        add(0, 0, 4'b0001, 1, 4'b0001, 1, 0, 0, 3, 0);
        add(0, 0, 4'b0001, 1, 4'b0000, 1, 0, 0, 4, 1);
        add(0, 0, 4'b0001, 0, 4'b0001, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 0, 4'b0000, 1, 0, 0, 5, 0);

        // Sources 1 and 3: source 1 gaps for 5 cycles after beat 2, then reset mid-burst
        add(1, 0, 4'b1010, 1, 4'b0000, 0, 1, 0, 0, 0);
        add(0, 0, 4'b1010, 1, 4'b0010, 0, 0, 0, 0, 0);
        add(0, 0, 4'b1010, 1, 4'b0010, 1, 0, 1, 1, 0);
        add(0, 0, 4'b1000, 1, 4'b0010, 1, 0, 1, 2, 0);
        for (int j = 0; j < 4; j++)
            add(0, 0, 4'b1000, 1, 4'b0010, 0, 0, 0, 0, 0);
        add(0, 0, 4'b1010, 1, 4'b0010, 0, 0, 0, 0, 0);
        add(0, 0, 4'b1010, 1, 4'b0010, 1, 0, 1, 3, 0);
        add(0, 0, 4'b1010, 1, 4'b0000, 1, 0, 1, 4, 1);
        if (FIXED) begin
            add(0, 0, 4'b1010, 1, 4'b0010, 0, 0, 0, 0, 0);
            add(0, 0, 4'b1010, 1, 4'b0010, 1, 0, 1, 5, 0);
            add(0, 1, 4'b1010, 1, 4'b0000, 1, 0, 1, 6, 0);
        end else begin
            add(0, 0, 4'b1010, 1, 4'b1000, 0, 0, 0, 0, 0);
            add(0, 0, 4'b1010, 1, 4'b1000, 1, 0, 3, 1, 0);
            add(0, 1, 4'b1010, 1, 4'b0000, 1, 0, 3, 2, 0);
        end
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 1, 0, 0, 0);
        add(0, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, 0, 0);
        add(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 0, 1, 0);

        for (int k = 0; k < rows.size(); k++) begin
            if (rows[k].start) do_reset();
            @(negedge clk);
            rst      = rows[k].rst;
            m_tready = rows[k].mr;
            s_tvalid = rows[k].tv;
            for (int i = 0; i < N; i++)
                s_tdata[i*DW +: DW] = (DW'(i) << 16) | DW'(seq_cnt[i] + 1);
            #1;
            check("s_tready", k, 64'(s_tready), 64'(rows[k].rdy));
            check("m_tvalid", k, 64'(m_tvalid), 64'(rows[k].mv));
            if (rows[k].zero) begin
                check("reset_tdata", k, 64'(m_tdata), 64'd0);
                check("reset_tdest", k, 64'(m_tdest), 64'd0);
                check("reset_tlast", k, 64'(m_tlast), 64'd0);
            end else if (rows[k].mv) begin
                exp_data = (DW'(rows[k].dest) << 16) | DW'(rows[k].seq);
                check("m_tdata", k, 64'(m_tdata), 64'(exp_data));
                check("m_tdest", k, 64'(m_tdest), 64'(rows[k].dest));
                check("m_tlast", k, 64'(m_tlast), 64'(rows[k].last));
                $display("[TB] row %0d beat dest=%0d data=%0h last=%0b ready=%0b",
                         k, m_tdest, m_tdata, m_tlast, m_tready);
            end
            for (int i = 0; i < N; i++)
                if (s_tready[i] && s_tvalid[i]) seq_cnt[i]++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
